// File: rtl/counter_pkg.sv
// Shared encodings for the parameterised up/down counter.
package counter_pkg;

   // Counting mode selected on the mode input; the reserved code behaves as wrap.
   typedef enum logic [1:0] {
      MODE_WRAP    = 2'b00,
      MODE_SAT     = 2'b01,
      MODE_ONESHOT = 2'b10,
      MODE_RSVD    = 2'b11
   } mode_e;

   // One-shot sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/counter_param.sv
// Up/down counter with programmable limit: wrap, saturate and one-shot modes,
// registered terminal-count pulse and sticky overflow flag.
module counter_param
   import counter_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
   input  logic [1:0]       mode,
   input  logic             start,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             ovf,
   output logic             busy
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   state_e           state_q, state_d;

   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] end_val;
   logic             at_top;
   logic             at_bot;
   logic             ovf_set;
   logic             is_oneshot;

   // Terminal detection: a count above limit (only reachable by load) counts as top.
   assign at_top     = up && (count_q >= limit);
   assign at_bot     = !up && (count_q == '0);
   assign step_val   = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
   assign end_val    = up ? limit : '0;
   assign is_oneshot = (mode == MODE_ONESHOT);

   // Next-state logic: load beats start, start beats an enabled step.
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      ovf_set = 1'b0;
      state_d = state_q;

      if (!is_oneshot) begin
         state_d = ST_IDLE;
      end

      if (load) begin
         count_d = load_val;
      end else if (is_oneshot && start && (state_q != ST_RUN)) begin
         count_d = up ? '0 : limit;
         state_d = ST_RUN;
      end else if (en) begin
         case (mode)
            MODE_SAT: begin
               if (at_top || at_bot) begin
                  tc_d    = 1'b1;
                  ovf_set = 1'b1;
               end else begin
                  count_d = step_val;
               end
            end
            MODE_ONESHOT: begin
               if (state_q == ST_RUN) begin
                  if (at_top || at_bot) begin
                     state_d = ST_DONE;
                     tc_d    = 1'b1;
                  end else begin
                     count_d = step_val;
                     if (step_val == end_val) begin
                        state_d = ST_DONE;
                        tc_d    = 1'b1;
                     end
                  end
               end
            end
            default: begin
               if (at_top) begin
                  count_d = '0;
                  tc_d    = 1'b1;
                  ovf_set = 1'b1;
               end else if (at_bot) begin
                  count_d = limit;
                  tc_d    = 1'b1;
                  ovf_set = 1'b1;
               end else begin
                  count_d = step_val;
               end
            end
         endcase
      end

      ovf_d = ovf_set | (ovf_q & ~clr_flags);
   end

   // State register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= RESET_VAL;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
         state_q <= ST_IDLE;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
         state_q <= state_d;
      end
   end

   assign count = count_q;
   assign tc    = tc_q;
   assign ovf   = ovf_q;
   assign busy  = (state_q == ST_RUN);

endmodule

// File: tb/tb_counter_param.sv
// Directed bench for counter_param: wrap, saturate, one-shot, limit=0,
// out-of-range load, mode switch and asynchronous reset.
module tb_counter_param;

   localparam int         WIDTH = 8;
   localparam logic [7:0] RV    = 8'd3;

   logic             clk = 1'b0;
   logic             reset;
   logic             en, up, load, start, clr_flags;
   logic [WIDTH-1:0] load_val, limit;
   logic [1:0]       mode;
   logic [WIDTH-1:0] count;
   logic             tc, ovf, busy;

   int checks = 0;
   int errors = 0;

   counter_param #(.WIDTH(WIDTH), .RESET_VAL(RV)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .up        (up),
      .load      (load),
      .load_val  (load_val),
      .limit     (limit),
      .mode      (mode),
      .start     (start),
      .clr_flags (clr_flags),
      .count     (count),
      .tc        (tc),
      .ovf       (ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [7:0] c, input logic t,
                          input logic o, input logic b);
      chk({tag, ".count"}, 32'(count), 32'(c));
      chk({tag, ".tc"},    32'(tc),    32'(t));
      chk({tag, ".ovf"},   32'(ovf),   32'(o));
      chk({tag, ".busy"},  32'(busy),  32'(b));
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      en = 0; up = 1; load = 0; start = 0; clr_flags = 0;
      load_val = '0; limit = '0; mode = 2'b00;

      // Reset state
      reset = 1'b0;
      #12;
      chk_all("reset", RV, 0, 0, 0);
      reset = 1'b1;

      // Wrap up, limit 5, from 0
      load = 1; load_val = 8'd0; limit = 8'd5; mode = 2'b00; up = 1;
      cyc();
      load = 0;
      chk_all("wrap_load0", 8'd0, 0, 0, 0);
      en = 1;
      for (int i = 1; i <= 5; i++) begin
         cyc();
         chk_all("wrap_up", 8'(i), 0, 0, 0);
      end
      cyc();
      chk_all("wrap_top", 8'd0, 1, 1, 0);
      en = 0;
      cyc();
      chk_all("wrap_tc_pulse", 8'd0, 0, 1, 0);
      clr_flags = 1;
      cyc();
      clr_flags = 0;
      chk("ovf_clear", 32'(ovf), 32'd0);

      // Saturate down from 2
      mode = 2'b01; up = 0; load = 1; load_val = 8'd2;
      cyc();
      load = 0;
      chk_all("sat_load", 8'd2, 0, 0, 0);
      en = 1;
      cyc(); chk_all("sat_dn1", 8'd1, 0, 0, 0);
      cyc(); chk_all("sat_dn0", 8'd0, 0, 0, 0);
      cyc(); chk_all("sat_hold", 8'd0, 1, 1, 0);
      clr_flags = 1;
      cyc(); chk_all("sat_set_wins", 8'd0, 1, 1, 0);
      en = 0;
      cyc(); chk_all("sat_clr", 8'd0, 0, 0, 0);
      clr_flags = 0;

      // Saturate up at limit
      up = 1; limit = 8'd5; load = 1; load_val = 8'd4;
      cyc();
      load = 0; en = 1;
      cyc(); chk_all("sat_up5", 8'd5, 0, 0, 0);
      cyc(); chk_all("sat_top", 8'd5, 1, 1, 0);
      en = 0;

      // Wrap down through bottom reloads limit
      mode = 2'b00; up = 0; load = 1; load_val = 8'd1; clr_flags = 1;
      cyc();
      load = 0; clr_flags = 0; en = 1;
      cyc(); chk_all("wrapdn_0", 8'd0, 0, 0, 0);
      cyc(); chk_all("wrapdn_bot", 8'd5, 1, 1, 0);
      en = 0;

      // One-shot up, limit 3
      mode = 2'b10; up = 1; limit = 8'd3; start = 1; clr_flags = 1;
      cyc();
      start = 0; clr_flags = 0;
      chk_all("os_start", 8'd0, 0, 0, 1);
      en = 1;
      cyc(); chk_all("os_1", 8'd1, 0, 0, 1);
      cyc(); chk_all("os_2", 8'd2, 0, 0, 1);
      cyc(); chk_all("os_done", 8'd3, 1, 0, 0);
      cyc(); chk_all("os_hold", 8'd3, 0, 0, 0);
      start = 1;
      cyc();
      start = 0;
      chk_all("os_restart", 8'd0, 0, 0, 1);
      cyc(); chk_all("os_r1", 8'd1, 0, 0, 1);
      cyc(); chk_all("os_r2", 8'd2, 0, 0, 1);

      // Asynchronous reset mid-RUN
      en = 0;
      #2;
      reset = 1'b0;
      #1;
      chk_all("async_reset", RV, 0, 0, 0);
      reset = 1'b1;
      cyc();
      chk_all("post_reset", RV, 0, 0, 0);

      // One-shot with limit 0
      limit = 8'd0; up = 1; start = 1;
      cyc();
      start = 0;
      chk_all("os_lim0_run", 8'd0, 0, 0, 1);
      en = 1;
      cyc(); chk_all("os_lim0_done", 8'd0, 1, 0, 0);
      cyc(); chk_all("os_lim0_hold", 8'd0, 0, 0, 0);

      // Wrap with limit 0: continuous tc
      mode = 2'b00;
      cyc(); chk_all("wrap_lim0_a", 8'd0, 1, 1, 0);
      cyc(); chk_all("wrap_lim0_b", 8'd0, 1, 1, 0);
      en = 0;

      // Load above limit is treated as top
      limit = 8'd100; load = 1; load_val = 8'd200;
      cyc();
      load = 0;
      chk_all("big_load", 8'd200, 0, 1, 0);
      en = 1;
      cyc(); chk_all("big_wrap", 8'd0, 1, 1, 0);
      load = 1;
      cyc(); chk_all("load_wins", 8'd200, 0, 1, 0);
      load = 0; en = 0;

      // Mode switch 10 -> 00 during RUN
      mode = 2'b10; limit = 8'd10; up = 1; start = 1; clr_flags = 1;
      cyc();
      start = 0; clr_flags = 0;
      chk_all("sw_start", 8'd0, 0, 0, 1);
      en = 1;
      cyc(); chk_all("sw_run1", 8'd1, 0, 0, 1);
      mode = 2'b00;
      cyc(); chk_all("sw_wrap2", 8'd2, 0, 0, 0);
      cyc(); chk_all("sw_wrap3", 8'd3, 0, 0, 0);
      en = 0; start = 1;
      cyc(); chk_all("sw_start_ignored", 8'd3, 0, 0, 0);
      start = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time bound so the bench always terminates.
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/counter_param.md
COUNTER_PARAM -- requirements
Module: counter_param

Interface
REQ-001 Parameter WIDTH, default 8: count, load_val and limit width in bits (legal 2..32).
REQ-002 Parameter RESET_VAL, default 0: count value after reset.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  count enable, one step per cycle when high.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous load of load_val.
REQ-008 load_val  input  WIDTH  value taken on load.
REQ-009 limit  input  WIDTH  programmable terminal value (upper bound).
REQ-010 mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (behaves as wrap).
REQ-011 start  input  1  one-shot launch pulse.
REQ-012 clr_flags  input  1  clears sticky ovf.
REQ-013 count  output  WIDTH  current count, registered.
REQ-014 tc  output  1  terminal-count pulse, registered, one cycle.
REQ-015 ovf  output  1  sticky overflow/underflow flag.
REQ-016 busy  output  1  high while one-shot is in RUN.

Function
REQ-017 Priority per cycle SHALL be: load > start > en step; load overrides stepping and never asserts tc or sets ovf.
REQ-018 "Top" SHALL be reached when up=1 and count >= limit; "bottom" when up=0 and count == 0.
REQ-019 Wrap, en=1: at top, count <= 0; at bottom, count <= limit; otherwise count +/- 1; tc=1 and ovf set on each wrap.
REQ-020 Saturate, en=1: at top or bottom, count holds, tc=1 and ovf set; otherwise count +/- 1.
REQ-021 One-shot SHALL use FSM IDLE/RUN/DONE; busy=1 only in RUN.
REQ-022 IDLE or DONE + start: count <= 0 (up=1) or limit (up=0), go RUN; no tc.
REQ-023 RUN + en: step by one; on the step reaching limit (up) or 0 (down), go DONE and pulse tc; ovf not set.
REQ-024 RUN + en=0: count and state hold; DONE holds count until start.
REQ-025 Mode other than 10 SHALL force FSM to IDLE next cycle, busy=0; start ignored.
REQ-026 ovf: set on events in REQ-019/020; clr_flags clears; simultaneous set and clear, set wins.
REQ-027 tc high exactly one cycle after the edge of the terminal event; consecutive events give continuous tc.
REQ-028 limit=0: wrap up holds count 0 and pulses tc every enabled cycle; one-shot start with limit=0 goes RUN, next enabled cycle DONE.
REQ-029 Arithmetic modulo 2^WIDTH internally; no out-of-range count is produced except via load (load_val > limit permitted, treated as top).

Reset
REQ-030 reset low SHALL asynchronously force count=RESET_VAL, tc=0, ovf=0, busy=0, FSM=IDLE, including mid-RUN.
REQ-031 Release SHALL be synchronised externally; first active edge after release behaves as normal operation.

Structure
REQ-032 Shared package counter_pkg SHALL hold mode encodings (MODE_WRAP, MODE_SAT, MODE_ONESHOT) and FSM state enum.
REQ-033 No sub-module; single module with one sequential process and next-state logic.

Verification
REQ-034 WIDTH=8, wrap, up, limit=5, en=1 from 0: count 0..5,0; tc one cycle after 5->0; ovf=1.
REQ-035 Saturate, down from load_val=2: count 2,1,0,0; tc high each cycle held at 0; clr_flags with event same cycle -> ovf stays 1.
REQ-036 One-shot, up, limit=3, start then en=1: busy 1 for 3 cycles, count 0,1,2,3, tc once, DONE holds 3; second start restarts at 0.
REQ-037 One-shot RUN at count 2, reset low asynchronously: immediately count=RESET_VAL, busy=0, tc=0, ovf=0.
REQ-038 load_val=200, limit=100, wrap up, en=1: next cycle count 0, tc=1; load and en same cycle -> load wins, no tc.
REQ-039 Mode switched 10->00 during RUN: busy drops next cycle, counting continues under wrap rules.
